// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: ALU results take priority, long-latency results queue in a FIFO.
// Tracks pending long-latency writes per register. Optional starvation guard: RF_WB_STARVE_GUARD_EN.
module rf_wb_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alu_valid,
    input  logic [4:0]               alu_wR,
    input  logic [31:0]              alu_wD,
    input  logic                     lsu_valid,
    output logic                     lsu_ready,
    input  logic [4:0]               lsu_wR,
    input  logic [31:0]              lsu_wD,
    input  logic                     issue_valid,
    input  logic [4:0]               issue_wR,
    input  logic [4:0]               rR1,
    input  logic [4:0]               rR2,
    output logic                     hazard,
    output logic                     rf_we,
    output logic [4:0]               rf_wR,
    output logic [31:0]              rf_wD,
`ifdef RF_WB_STARVE_GUARD_EN
    output logic                     alu_stall,
`endif
    output logic [$clog2(DEPTH):0]   fifo_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [4:0]       fifo_wr [DEPTH];
    logic [31:0]      fifo_wd [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [31:0]      busy;
    logic [31:0]      busy_next;
    logic             fifo_nonempty;
    logic             push;
    logic             pop;
    logic             alu_win;
    logic             any_win;
    logic [4:0]       win_wR;
    logic [31:0]      win_wD;

    assign fifo_nonempty = (fifo_cnt != '0);
    // Readiness uses only the registered count, so a full FIFO never accepts even while popping.
    assign lsu_ready     = (fifo_cnt < CNT_W'(DEPTH));
    assign push          = lsu_valid & lsu_ready;

`ifdef RF_WB_STARVE_GUARD_EN
    assign alu_win = alu_valid & ~alu_stall;
`else
    assign alu_win = alu_valid;
`endif

    assign pop     = ~alu_win & fifo_nonempty;
    assign any_win = alu_win | pop;
    assign win_wR  = alu_win ? alu_wR : fifo_wr[rd_ptr];
    assign win_wD  = alu_win ? alu_wD : fifo_wd[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_wr[wr_ptr] <= lsu_wR;
            fifo_wd[wr_ptr] <= lsu_wD;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                fifo_cnt <= fifo_cnt + 1'b1;
            end else if (pop && !push) begin
                fifo_cnt <= fifo_cnt - 1'b1;
            end
        end
    end

    // Clear is applied before set so an issue to the register being retired keeps it busy.
    always_comb begin
        busy_next = busy;
        if (pop) begin
            busy_next[fifo_wr[rd_ptr]] = 1'b0;
        end
        if (issue_valid && (issue_wR != 5'd0)) begin
            busy_next[issue_wR] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    assign hazard = busy[rR1] | busy[rR2];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_we <= 1'b0;
            rf_wR <= '0;
            rf_wD <= '0;
        end else if (any_win) begin
            rf_we <= (win_wR != 5'd0);
            rf_wR <= win_wR;
            rf_wD <= win_wD;
        end else begin
            rf_we <= 1'b0;
        end
    end

`ifdef RF_WB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0] starve_cnt;

    // Stall fires the cycle after the limit-th consecutive ALU win over a waiting FIFO head.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt <= '0;
            alu_stall  <= 1'b0;
        end else if (alu_win && fifo_nonempty) begin
            starve_cnt <= starve_cnt + 1'b1;
            alu_stall  <= (starve_cnt == SW'(STARVE_LIMIT - 1));
        end else begin
            starve_cnt <= '0;
            alu_stall  <= 1'b0;
        end
    end

    a_no_alu_during_stall: assert property (@(posedge clk) disable iff (!rst_n) !(alu_stall && alu_valid))
        else $error("alu_valid asserted during alu_stall; ALU result dropped");
`endif

endmodule
